// File: rtl/acc_pkg.sv
// Shared definitions for the op-decoded accumulator: opcodes and FSM states.
package acc_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/acc_mul_seq.sv
// Iterative unsigned shift-and-add multiplier datapath, one multiplier bit per edge.
// o_product is the product including the current iteration, so the owner can commit it on the last edge.
module acc_mul_seq
    import acc_pkg::*;
#(
    parameter int E_BITS = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_step,
    input  logic [E_BITS-1:0]     i_a,
    input  logic [E_BITS-1:0]     i_b,
    output logic [2*E_BITS-1:0]   o_product,
    output logic                  o_last_iter
);

    localparam int CW = $clog2(E_BITS + 1);

    logic [2*E_BITS-1:0] r_mcand;
    logic [E_BITS-1:0]   r_mplier;
    logic [2*E_BITS-1:0] r_prod;
    logic [CW-1:0]       r_cnt;
    logic [2*E_BITS-1:0] w_prod_next;

    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign o_product   = w_prod_next;
    assign o_last_iter = (r_cnt == CW'(E_BITS - 1));

    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= {{E_BITS{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/acc_unit.sv
// Op-decoded accumulator with registered zero/neg/ovf flags and a multi-cycle multiply.
// All state updates on the falling edge of i_clock; i_reset is synchronous and active-high.
module acc_unit
    import acc_pkg::*;
#(
    parameter int E_BITS = 16,
    parameter bit SAT_EN = 1'b0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [2:0]        i_op,
    input  logic [E_BITS-1:0] i_operand,
    output logic [E_BITS-1:0] o_acc,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_ovf
);

    localparam int MSB = E_BITS - 1;
    localparam logic [E_BITS-1:0] SAT_MAX = {1'b0, {(E_BITS-1){1'b1}}};
    localparam logic [E_BITS-1:0] SAT_MIN = {1'b1, {(E_BITS-1){1'b0}}};

    acc_state_t r_state, w_next_state;

    logic [E_BITS-1:0]   r_acc;
    logic                r_done, r_zero, r_neg, r_ovf;

    logic                w_wr;
    logic [E_BITS-1:0]   w_val;
    logic                w_ovf;
    logic                w_start;
    logic                w_done;
    logic [E_BITS-1:0]   w_sum, w_diff, w_sat;
    logic                w_add_ovf, w_sub_ovf;
    logic [2*E_BITS-1:0] w_product;
    logic                w_last_iter;

    assign w_sum     = r_acc + i_operand;
    assign w_diff    = r_acc - i_operand;
    assign w_add_ovf = (r_acc[MSB] == i_operand[MSB]) && (w_sum[MSB] != r_acc[MSB]);
    assign w_sub_ovf = (r_acc[MSB] != i_operand[MSB]) && (w_diff[MSB] != r_acc[MSB]);
    // On signed overflow the true result always carries the accumulator's sign.
    assign w_sat     = r_acc[MSB] ? SAT_MIN : SAT_MAX;

    acc_mul_seq #(.E_BITS(E_BITS)) u_mul (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (w_start),
        .i_step      (r_state == ST_MUL),
        .i_a         (r_acc),
        .i_b         (i_operand),
        .o_product   (w_product),
        .o_last_iter (w_last_iter)
    );

    always_comb begin
        w_next_state = r_state;
        w_wr         = 1'b0;
        w_val        = r_acc;
        w_ovf        = 1'b0;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    case (i_op)
                        OP_LOAD: begin
                            w_wr  = 1'b1;
                            w_val = i_operand;
                        end
                        OP_ADD: begin
                            w_wr  = 1'b1;
                            w_ovf = w_add_ovf;
                            w_val = (SAT_EN && w_add_ovf) ? w_sat : w_sum;
                        end
                        OP_SUB: begin
                            w_wr  = 1'b1;
                            w_ovf = w_sub_ovf;
                            w_val = (SAT_EN && w_sub_ovf) ? w_sat : w_diff;
                        end
                        OP_AND: begin
                            w_wr  = 1'b1;
                            w_val = r_acc & i_operand;
                        end
                        OP_OR: begin
                            w_wr  = 1'b1;
                            w_val = r_acc | i_operand;
                        end
                        OP_MUL: begin
                            w_start      = 1'b1;
                            w_next_state = ST_MUL;
                        end
                        OP_CLR: begin
                            w_wr  = 1'b1;
                            w_val = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (w_last_iter) begin
                    w_wr         = 1'b1;
                    w_val        = w_product[E_BITS-1:0];
                    w_ovf        = |w_product[2*E_BITS-1:E_BITS];
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_done  <= 1'b0;
            r_zero  <= 1'b1;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done;
            if (w_wr) begin
                r_acc  <= w_val;
                r_zero <= (w_val == '0);
                r_neg  <= w_val[MSB];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign o_acc  = r_acc;
    assign o_busy = (r_state == ST_MUL);
    assign o_done = r_done;
    assign o_zero = r_zero;
    assign o_neg  = r_neg;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit: a wrapping and a saturating instance share the same stimulus.
module tb_acc_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [15:0] opnd;

    logic [15:0] acc0, acc1;
    logic        busy0, done0, zero0, neg0, ovf0;
    logic        busy1, done1, zero1, neg1, ovf1;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cycles;

    acc_unit #(.E_BITS(16), .SAT_EN(1'b0)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_op(op), .i_operand(opnd),
        .o_acc(acc0), .o_busy(busy0), .o_done(done0),
        .o_zero(zero0), .o_neg(neg0), .o_ovf(ovf0)
    );

    acc_unit #(.E_BITS(16), .SAT_EN(1'b1)) u_dut_sat (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_op(op), .i_operand(opnd),
        .o_acc(acc1), .o_busy(busy1), .o_done(done1),
        .o_zero(zero1), .o_neg(neg1), .o_ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] acc, input logic z,
                             input logic n, input logic v, input logic [15:0] e_acc,
                             input logic e_z, input logic e_n, input logic e_v);
        chk({tag, ".acc"}, acc, e_acc);
        chk({tag, ".zero"}, {15'b0, z}, {15'b0, e_z});
        chk({tag, ".neg"}, {15'b0, n}, {15'b0, e_n});
        chk({tag, ".ovf"}, {15'b0, v}, {15'b0, e_v});
    endtask

    // Drive inputs for one falling edge, then sample 1 time unit after it.
    task automatic step(input logic e, input logic [2:0] o, input logic [15:0] d);
        en   = e;
        op   = o;
        opnd = d;
        @(negedge clk);
        #1;
        en = 1'b0;
        op = 3'd0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = 3'd0; opnd = 16'h0;
        step(1'b0, 3'd0, 16'h0);
        step(1'b0, 3'd0, 16'h0);
        rst = 1'b0;

        // Reset with nonzero accumulator
        step(1'b1, 3'd1, 16'h00AB);
        chk("pre_reset_acc", acc0, 16'h00AB);
        rst = 1'b1;
        step(1'b0, 3'd0, 16'h0);
        rst = 1'b0;
        chk_state("reset", acc0, zero0, neg0, ovf0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("reset.busy", {15'b0, busy0}, 16'h0);
        chk("reset.done", {15'b0, done0}, 16'h0);

        // LOAD, ADD, NOP
        step(1'b1, 3'd1, 16'h1234);
        chk("load1234", acc0, 16'h1234);
        step(1'b1, 3'd2, 16'h0001);
        chk_state("add1", acc0, zero0, neg0, ovf0, 16'h1235, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 16'hFFFF);
        chk_state("nop", acc0, zero0, neg0, ovf0, 16'h1235, 1'b0, 1'b0, 1'b0);

        // Signed overflow, wrap vs. saturate
        step(1'b1, 3'd1, 16'h7FFF);
        step(1'b1, 3'd2, 16'h0001);
        chk_state("add_wrap", acc0, zero0, neg0, ovf0, 16'h8000, 1'b0, 1'b1, 1'b1);
        chk_state("add_sat", acc1, zero1, neg1, ovf1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'd1, 16'h8000);
        step(1'b1, 3'd3, 16'h0001);
        chk_state("sub_wrap", acc0, zero0, neg0, ovf0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        chk_state("sub_sat", acc1, zero1, neg1, ovf1, 16'h8000, 1'b0, 1'b1, 1'b1);

        // SUB to zero, OR, AND, CLR
        step(1'b1, 3'd1, 16'h0005);
        step(1'b1, 3'd3, 16'h0005);
        chk_state("sub_zero", acc0, zero0, neg0, ovf0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd5, 16'h00F0);
        chk_state("or", acc0, zero0, neg0, ovf0, 16'h00F0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd4, 16'h0030);
        chk_state("and", acc0, zero0, neg0, ovf0, 16'h0030, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 16'h8001);
        step(1'b1, 3'd7, 16'h1234);
        chk_state("clr", acc0, zero0, neg0, ovf0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // MUL 3*7 with ignored ADD issues while busy
        step(1'b1, 3'd1, 16'h0003);
        step(1'b1, 3'd6, 16'h0007);
        busy_cycles = 0;
        if (busy0) busy_cycles++;
        chk("mul.start_busy", {15'b0, busy0}, 16'h1);
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, 3'd2, 16'h0001);
            if (busy0) busy_cycles++;
            chk("mul.hold_acc", acc0, 16'h0003);
            chk("mul.no_done", {15'b0, done0}, 16'h0);
        end
        step(1'b1, 3'd2, 16'h0001);
        chk("mul.busy_cycles", 16'(busy_cycles), 16'd16);
        chk("mul.end_busy", {15'b0, busy0}, 16'h0);
        chk("mul.done", {15'b0, done0}, 16'h1);
        chk_state("mul3x7", acc0, zero0, neg0, ovf0, 16'h0015, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'h0);
        chk("mul.done_clear", {15'b0, done0}, 16'h0);
        chk("mul.acc_after", acc0, 16'h0015);

        // MUL overflow into upper half
        step(1'b1, 3'd1, 16'h0100);
        step(1'b1, 3'd6, 16'h0100);
        for (int k = 1; k <= 16; k++) step(1'b0, 3'd0, 16'h0);
        chk("mulovf.done", {15'b0, done0}, 16'h1);
        chk_state("mulovf", acc0, zero0, neg0, ovf0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk_state("mulovf_sat", acc1, zero1, neg1, ovf1, 16'h0000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd0, 16'h0);

        // MUL aborted by reset at iteration 5
        step(1'b1, 3'd1, 16'h00FF);
        step(1'b1, 3'd6, 16'h0002);
        for (int k = 1; k <= 4; k++) step(1'b0, 3'd0, 16'h0);
        chk("abort.busy_before", {15'b0, busy0}, 16'h1);
        rst = 1'b1;
        step(1'b0, 3'd0, 16'h0);
        rst = 1'b0;
        chk_state("abort", acc0, zero0, neg0, ovf0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("abort.busy", {15'b0, busy0}, 16'h0);
        chk("abort.done", {15'b0, done0}, 16'h0);
        step(1'b1, 3'd1, 16'h0001);
        chk("abort.load", acc0, 16'h0001);
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 3'd0, 16'h0);
            chk("abort.no_done", {15'b0, done0}, 16'h0);
        end
        chk("abort.acc_hold", acc0, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_unit.md
Name: acc_unit

Overview:
Parametrised accumulator unit for the accumulator-based CPU datapath. It replaces the plain enable-load accumulator register with an op-decoded accumulator. Single-cycle ops are load, add, subtract, and, or, and clear. A multi-cycle shift-and-add multiply has a busy/done handshake. Registered status flags (zero, negative, overflow) feed the control unit's branch logic.

Parameters:
E_BITS, 16, accumulator/operand width in bits (>= 4).
SAT_EN, 0, 1 = ADD/SUB saturate to signed max/min on overflow; 0 = wrap.

Ports:
i_clock  input  1  system clock; all state updates on the falling edge.
i_reset  input  1  reset i_reset, synchronous, active-high.
i_enable  input  1  issue strobe; op sampled when high and o_busy low.
i_op  input  3  opcode: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 MUL, 7 CLR.
i_operand  input  E_BITS  operand (the datapath mux output).
o_acc  output  E_BITS  accumulator value.
o_busy  output  1  multiply in progress.
o_done  output  1  one-cycle pulse when the multiply result is written.
o_zero  output  1  last written result == 0.
o_neg  output  1  MSB of last written result.
o_ovf  output  1  overflow of last written result.

Behaviour:
- Reset, sampled on the falling edge:
  - o_acc=0, o_busy=0, o_done=0, o_zero=1, o_neg=0, o_ovf=0.
  - FSM goes to IDLE and the iteration counter goes to 0.
  - Reset has priority over everything, including a multiply in progress: the multiply is aborted and no o_done pulse is issued.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on an accepted MUL issue.
  - MUL -> IDLE after E_BITS iterations.
- Issue acceptance: only in IDLE, on a falling edge with i_enable=1.
  - In MUL, i_enable and i_op are ignored; there is no queueing.
- Single-cycle ops: o_acc and flags are written on the accepting edge (latency 1 edge).
  - LOAD: acc=operand; ovf=0.
  - ADD/SUB: two's-complement signed; E_BITS-wide result.
    - ovf = operands have the same sign (ADD) or different signs (SUB) and the result sign differs from acc's sign.
    - With SAT_EN=1 and ovf, acc = 0111..1 if the true result is positive, 1000..0 if negative; ovf=1 still reported.
  - AND/OR: bitwise with operand; ovf=0.
  - CLR: acc=0; flags zero=1, neg=0, ovf=0.
  - NOP: nothing written; flags hold.
- Flags: zero/neg are always derived from the value being written to acc, in the same edge. Flags hold whenever acc is not written.
- MUL, unsigned, shift-and-add, 1 bit per cycle:
  - Accepting edge (edge 0): latch multiplicand=acc and multiplier=operand; clear a 2*E_BITS product register; set o_busy=1; counter=0.
  - Edges 1..E_BITS: if the multiplier LSB=1, add the shifted multiplicand into the product; shift multiplier right and multiplicand left; counter++.
  - On edge E_BITS:
    - acc = product[E_BITS-1:0].
    - ovf = (product[2E-1:E] != 0).
    - zero/neg from the low half.
    - o_busy=0, o_done=1.
  - o_done returns to 0 on edge E_BITS+1.
  - A new op may be accepted on edge E_BITS+1.
  - o_acc holds its pre-multiply value throughout MUL.
  - SAT_EN does not affect MUL.
- o_done and o_busy are never high in the same cycle.
- Op codes outside the list are impossible (3-bit op, all 8 codes defined).

Decomposition:
- Shared package acc_pkg: opcode localparams (OP_NOP..OP_CLR), FSM state encodings (ST_IDLE, ST_MUL).
- One sub-module: acc_mul_seq holds the iterative multiplier datapath.
  - Inputs: start, a, b.
  - Outputs: product, last_iter.
  - acc_unit owns the FSM, o_acc, flags and handshake.

Test Plan:
- Reset with a nonzero acc, then hold i_reset one edge -> o_acc=0x0000, zero=1, neg=0, ovf=0, busy=0, done=0.
- LOAD 0x1234, ADD 0x0001 -> o_acc=0x1235 after 1 edge each, all flags 0. NOP with i_enable=1 -> acc/flags unchanged.
- LOAD 0x7FFF, ADD 0x0001:
  - SAT_EN=0 -> 0x8000, neg=1, ovf=1.
  - SAT_EN=1 -> 0x7FFF, ovf=1, neg=0.
  - LOAD 0x8000, SUB 0x0001 with SAT_EN=1 -> 0x8000, ovf=1.
- LOAD 0x0005, SUB 0x0005 -> 0x0000, zero=1; then OR 0x00F0 -> 0x00F0; AND 0x0030 -> 0x0030; CLR -> 0x0000, zero=1.
- LOAD 0x0003, MUL 0x0007:
  - busy=1 for 16 cycles; ADD issues pulsed during busy are ignored; o_acc stays 0x0003.
  - Then acc=0x0015, done pulses exactly 1 cycle, ovf=0.
  - LOAD 0x0100, MUL 0x0100 -> acc=0x0000, zero=1, ovf=1.
- LOAD 0x00FF, MUL 0x0002, assert i_reset at iteration 5 -> acc=0, busy=0, done never pulses; next LOAD 0x0001 accepted on the following edge.
